// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer: iterative AES-128 encryption controller.
// Owns the 128-bit state and round-key registers and steps one shared,
// external round datapath plus one external key-expansion step through
// the initial AddRoundKey and NR rounds. Each round holds the operands on
// dp_state/dp_key/dp_rcon for DP_LAT cycles, then captures the results.
// Input and output blocks use valid/ready handshakes.

module aes_round_sequencer #(
    parameter int NR     = 10,
    parameter int DP_LAT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_text,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_text,
    output logic [127:0] dp_state,
    output logic [127:0] dp_key,
    output logic [7:0]   dp_rcon,
    output logic         dp_last,
    input  logic [127:0] dp_state_nxt,
    input  logic [127:0] dp_key_nxt,
    output logic         busy,
    output logic [3:0]   round
);

    // Wait counter only has to reach DP_LAT-1; keep it at least one bit wide.
    localparam int CW = (DP_LAT > 1) ? $clog2(DP_LAT) : 1;
    localparam logic [CW-1:0] CNT_LAST   = CW'(DP_LAT - 1);
    localparam logic [3:0]    ROUND_LAST = 4'(NR);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ROUND = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    // Multiply by x in GF(2^8) modulo the AES polynomial; yields the rcon sequence.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    logic [1:0]    fsm_r;
    logic [CW-1:0] cnt_r;
    logic [127:0]  text_r;
    logic [127:0]  key_r;
    logic [7:0]    rcon_r;
    logic [3:0]    round_r;
    logic          last_r;
    logic          busy_r;
    logic          in_ready_r;
    logic          out_valid_r;
    logic [127:0]  out_text_r;

    logic          accept_s;
    logic          step_s;
    logic          final_s;
    logic          release_s;
    logic [1:0]    fsm_nxt_s;
    logic [3:0]    round_nxt_s;
    logic [CW-1:0] cnt_nxt_s;

    // Decode the handshake and round-completion events for the current state.
    always_comb begin
        accept_s  = 1'b0;
        step_s    = 1'b0;
        final_s   = 1'b0;
        release_s = 1'b0;
        case (fsm_r)
            S_IDLE: begin
                accept_s = in_valid & in_ready_r;
            end
            S_ROUND: begin
                step_s  = (cnt_r == CNT_LAST);
                final_s = (cnt_r == CNT_LAST) & (round_r == ROUND_LAST);
            end
            S_DONE: begin
                release_s = out_valid_r & out_ready;
            end
            default: begin
                accept_s = 1'b0;
            end
        endcase
    end

    // Next FSM state; an unreachable encoding falls back to IDLE.
    always_comb begin
        fsm_nxt_s = fsm_r;
        case (fsm_r)
            S_IDLE: begin
                if (accept_s) begin
                    fsm_nxt_s = S_ROUND;
                end else begin
                    fsm_nxt_s = S_IDLE;
                end
            end
            S_ROUND: begin
                if (final_s) begin
                    fsm_nxt_s = S_DONE;
                end else begin
                    fsm_nxt_s = S_ROUND;
                end
            end
            S_DONE: begin
                if (release_s) begin
                    fsm_nxt_s = S_IDLE;
                end else begin
                    fsm_nxt_s = S_DONE;
                end
            end
            default: begin
                fsm_nxt_s = S_IDLE;
            end
        endcase
    end

    // Next round number: 1 on accept, +1 per completed round, 0 after release.
    always_comb begin
        round_nxt_s = round_r;
        if (accept_s) begin
            round_nxt_s = 4'd1;
        end else if (step_s && !final_s) begin
            round_nxt_s = round_r + 4'd1;
        end else if (release_s) begin
            round_nxt_s = 4'd0;
        end else if (fsm_r == 2'd3) begin
            round_nxt_s = 4'd0;
        end else begin
            round_nxt_s = round_r;
        end
    end

    // Next wait count: runs 0..DP_LAT-1 inside ROUND, parked at 0 elsewhere.
    always_comb begin
        cnt_nxt_s = '0;
        if ((fsm_r == S_ROUND) && !step_s) begin
            cnt_nxt_s = cnt_r + CW'(1);
        end else begin
            cnt_nxt_s = '0;
        end
    end

    // FSM state, wait counter and round number registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_r   <= S_IDLE;
            cnt_r   <= '0;
            round_r <= 4'd0;
        end else begin
            fsm_r   <= fsm_nxt_s;
            cnt_r   <= cnt_nxt_s;
            round_r <= round_nxt_s;
        end
    end

    // Status flags registered from the next state so they align with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b0;
            last_r      <= 1'b0;
        end else begin
            in_ready_r  <= (fsm_nxt_s == S_IDLE);
            busy_r      <= (fsm_nxt_s == S_ROUND);
            out_valid_r <= (fsm_nxt_s == S_DONE);
            last_r      <= (fsm_nxt_s == S_ROUND) && (round_nxt_s == ROUND_LAST);
        end
    end

    // State register: initial AddRoundKey on accept, datapath result per round.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            text_r <= 128'd0;
        end else if (accept_s) begin
            text_r <= in_text ^ in_key;
        end else if (step_s) begin
            text_r <= dp_state_nxt;
        end else begin
            text_r <= text_r;
        end
    end

    // Round-key register: cipher key on accept, expanded key per round.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_r <= 128'd0;
        end else if (accept_s) begin
            key_r <= in_key;
        end else if (step_s) begin
            key_r <= dp_key_nxt;
        end else begin
            key_r <= key_r;
        end
    end

    // Round constant: restarts at 01 per block and advances by xtime per round.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcon_r <= 8'h01;
        end else if (accept_s) begin
            rcon_r <= 8'h01;
        end else if (step_s) begin
            rcon_r <= xtime(rcon_r);
        end else begin
            rcon_r <= rcon_r;
        end
    end

    // Ciphertext register: loaded only when the last round completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_text_r <= 128'd0;
        end else if (final_s) begin
            out_text_r <= dp_state_nxt;
        end else begin
            out_text_r <= out_text_r;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_text  = out_text_r;
    assign dp_state  = text_r;
    assign dp_key    = key_r;
    assign dp_rcon   = rcon_r;
    assign dp_last   = last_r;
    assign busy      = busy_r;
    assign round     = round_r;

endmodule

// File: doc/aes_round_sequencer.md
Name: aes_round_sequencer

Overview:
- Iterative AES-128 encryption controller that owns the 128-bit state and round-key registers.
- Sequences one shared external round datapath (SubBytes, ShiftRows, MixColumns, AddRoundKey) and one shared external key-expansion step through the initial AddRoundKey plus 10 rounds.
- Sits between the I2C-facing block buffer and the round datapath.
- Uses valid/ready handshakes on both the input block and the output block.

Parameters:
- NR, 10: number of rounds. Fixed at 10 for AES-128; any other value is unsupported.
- DP_LAT, 1: cycles the external datapath needs per round, ≥1. The sequencer samples the datapath results DP_LAT cycles after presenting its operands.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  plaintext/key offered
- in_ready  out  1  sequencer can accept a block
- in_text  in  128  plaintext, byte 0 in [127:120]
- in_key  in  128  cipher key, same byte order
- out_valid  out  1  ciphertext available
- out_ready  in  1  consumer accepts ciphertext
- out_text  out  128  ciphertext
- dp_state  out  128  current state register, driven to the round datapath
- dp_key  out  128  current round-key register, driven to the key-expansion step
- dp_rcon  out  8  round constant for the key step of the current round
- dp_last  out  1  final round: the datapath bypasses MixColumns
- dp_state_nxt  in  128  round result = AddRoundKey(MixColumns'(ShiftRows(SubBytes(dp_state))), key_nxt)
- dp_key_nxt  in  128  next round key derived from dp_key and dp_rcon
- busy  out  1  high in ROUND
- round  out  4  current round number, 0 when idle

Behaviour:
- Reset (async, rst_n=0) forces the following, overriding any operation in flight:
  - FSM = IDLE; in_ready=1; out_valid=0.
  - out_text, dp_state, dp_key = 0; dp_rcon=8'h01; dp_last=0; round=0; busy=0; wait counter=0.
- FSM states:
  - IDLE:
    - in_ready=1.
    - On in_valid&in_ready at an edge: state_q <= in_text^in_key, key_q <= in_key, round <= 1, rcon <= 8'h01, wait counter <= 0, go to ROUND.
  - ROUND:
    - in_ready=0; busy=1; dp_last=(round==NR).
    - The wait counter increments each cycle.
    - When counter==DP_LAT-1:
      - state_q <= dp_state_nxt; key_q <= dp_key_nxt; counter <= 0.
      - rcon <= xtime(rcon), i.e. shift left by 1, XOR 8'h1b if bit7 was set. Sequence: 01,02,04,08,10,20,40,80,1b,36.
      - If round==NR: out_text <= dp_state_nxt, go to DONE. Otherwise round <= round+1.
  - DONE:
    - out_valid=1; in_ready=0; busy=0; round holds NR.
    - out_text stays stable while out_valid=1 and out_ready=0 (backpressure is held indefinitely).
    - On out_valid&out_ready: out_valid <= 0, round <= 0, go to IDLE.
    - in_ready rises in the cycle after the handshake; there is no same-cycle turnaround.
- Latency: from the input-handshake edge to out_valid high is NR*DP_LAT edges. With DP_LAT=1 this is 10 cycles, giving a throughput of one block per 12 cycles with out_ready tied high.
- Input ignoring:
  - in_valid is ignored outside IDLE.
  - in_text and in_key are sampled only at the accept edge; later changes to them have no effect.
- dp_state, dp_key and dp_rcon are registered outputs. They must hold steady for all DP_LAT cycles of a round.
- out_text changes only on entry to DONE.
- Reset mid-operation aborts the block: no out_valid is produced, and the next accepted block starts clean.
- Width rules: all XORs are 128-bit bitwise; round is a 4-bit unsigned value with no wrap, since the maximum is 10.

Test Plan:
- FIPS-197 C.1 vector, DP_LAT=1, bench datapath = golden round model:
  - Stimulus: in_text=00112233445566778899aabbccddeeff, in_key=000102030405060708090a0b0c0d0e0f.
  - Required: out_text=69c4e0d86a7b0430d8cdb78070b4c55a; out_valid rises exactly 10 edges after accept.
- FIPS-197 Appendix B, DP_LAT=3:
  - Stimulus: pt=3243f6a8885a308d313198a2e0370734, key=2b7e151628aed2a6abf7158809cf4f3c.
  - Required: out_text=3925841d02dc09fbdc118597196a0b32 after 30 edges.
  - Required: dp_rcon steps 01..36 in order; dp_last high only during round 10.
- Backpressure:
  - Stimulus: hold out_ready=0 for 20 cycles after out_valid.
  - Required: out_valid and out_text stable throughout; in_ready=0; a pulse of in_valid in that window is ignored.
  - Required: after out_ready=1 there is exactly one transfer, then in_ready=1 on the next cycle.
- Back-to-back with in_valid and out_ready tied high:
  - Stimulus: two blocks (C.1, then B).
  - Required: both ciphertexts correct; in_ready low from accept through the DONE handshake edge; 12-cycle period.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 asynchronously during round 5.
  - Required: all outputs go to reset values immediately; no out_valid appears; a subsequent C.1 block yields the correct ciphertext.
